// File: rtl/video_pkg.sv
// Shared types and constants for the video stream checker and stimulus blocks.
package video_pkg;

  typedef enum logic [1:0] {
    SEEK,
    ACTIVE,
    WAIT_SOF
  } chk_state_t;

  // Bit positions inside err_flags
  localparam int unsigned ERR_SOF_EARLY   = 0;
  localparam int unsigned ERR_SOF_MISSING = 1;
  localparam int unsigned ERR_EOL_EARLY   = 2;
  localparam int unsigned ERR_EOL_LATE    = 3;

  // Fibonacci taps 16,14,13,11 mapped onto state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; shifts toward the MSB, feedback enters at bit 0.
module lfsr16 import video_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  // Advance one step per enabled cycle; SEED must be nonzero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/video_axis_frame_checker.sv
// AXI4-Stream video sink: checks frame geometry, counts frames/errors,
// sums pixel data per frame and optionally throttles tready pseudo-randomly.
module video_axis_frame_checker import video_pkg::*; #(
  parameter int unsigned DATAW     = 24,
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bp_en,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             locked,
  output logic             frame_done,
  output logic [31:0]      frame_cnt,
  output logic [31:0]      frame_sum,
  output logic [15:0]      err_cnt,
  output logic [3:0]       err_flags,
  input  logic             clr_err
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [15:0] lfsr;
  logic        unused_lfsr;
  logic        tready_q;
  logic        beat;
  logic [31:0] data_ext;
  logic        line_end;
  logic        start_frame;
  logic [3:0]  err_set;

  chk_state_t  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0] sum_q, sum_d;
  logic        frame_ok_q, frame_ok_d;
  logic        locked_q, locked_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] frame_sum_q, frame_sum_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [3:0]  err_flags_q, err_flags_d;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .state (lfsr)
  );

  // Only bit 0 drives backpressure
  assign unused_lfsr = ^lfsr[15:1];

  // A handshake with the registered tready always counts, even in the first
  // cycle after en falls, so the producer never loses an accepted beat.
  assign beat     = s_axis_tvalid & tready_q;
  assign data_ext = 32'(s_axis_tdata);

  assign s_axis_tready = tready_q;
  assign locked        = locked_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign frame_sum     = frame_sum_q;
  assign err_cnt       = err_cnt_q;
  assign err_flags     = err_flags_q;

  // Registered tready, independent of tvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= en & (~bp_en | lfsr[0]);
    end
  end

  // Frame tracking: position, running sum, frame completion and error detection
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sum_d        = sum_q;
    frame_ok_d   = frame_ok_q;
    locked_d     = locked_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    frame_sum_d  = frame_sum_q;
    err_set      = '0;
    start_frame  = 1'b0;
    line_end     = 1'b0;
    if (beat) begin
      unique case (state_q)
        SEEK: begin
          if (s_axis_tuser) start_frame = 1'b1;
        end
        ACTIVE: begin
          line_end = s_axis_tlast | (x_q == X_LAST);
          if (s_axis_tlast && (x_q != X_LAST)) err_set[ERR_EOL_EARLY] = 1'b1;
          if (!s_axis_tlast && (x_q == X_LAST)) err_set[ERR_EOL_LATE] = 1'b1;
          if (s_axis_tuser) begin
            // Resync wins over any line-end handling on the same beat
            err_set[ERR_SOF_EARLY] = 1'b1;
            start_frame = 1'b1;
          end else begin
            sum_d = sum_q + data_ext;
            if (line_end) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                // Any line end on the last line closes the frame
                y_d          = '0;
                state_d      = WAIT_SOF;
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 32'd1;
                frame_sum_d  = sum_q + data_ext;
                locked_d     = frame_ok_q & (err_set == '0);
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        WAIT_SOF: begin
          if (s_axis_tuser) begin
            start_frame = 1'b1;
          end else begin
            err_set[ERR_SOF_MISSING] = 1'b1;
            state_d = SEEK;
          end
        end
        default: state_d = SEEK;
      endcase
      if (start_frame) begin
        // An early SOF taints the frame it starts, so it cannot lock
        state_d    = ACTIVE;
        sum_d      = data_ext;
        frame_ok_d = 1'b1;
        x_d        = (H_ACTIVE == 1) ? '0 : XW'(1);
        y_d        = (H_ACTIVE == 1) ? YW'(1) : '0;
      end
    end
    if (err_set != '0) begin
      locked_d   = 1'b0;
      frame_ok_d = 1'b0;
    end
  end

  // Sticky flags and saturating error count; a same-cycle error beats clr_err
  always_comb begin
    err_flags_d = err_flags_q | err_set;
    err_cnt_d   = err_cnt_q;
    if (clr_err) begin
      err_flags_d = err_set;
      err_cnt_d   = (err_set != '0) ? 16'd1 : 16'd0;
    end else if ((err_set != '0) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Checker state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEEK;
      x_q          <= '0;
      y_q          <= '0;
      sum_q        <= '0;
      frame_ok_q   <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      frame_sum_q  <= '0;
      err_cnt_q    <= '0;
      err_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sum_q        <= sum_d;
      frame_ok_q   <= frame_ok_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_sum_q  <= frame_sum_d;
      err_cnt_q    <= err_cnt_d;
      err_flags_q  <= err_flags_d;
    end
  end

endmodule

// File: tb/tb_video_axis_frame_checker.sv
// Directed bench for video_axis_frame_checker with a per-cycle reference model.
module tb_video_axis_frame_checker;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        bp_en = 1'b0;
  logic [23:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        locked;
  logic        frame_done;
  logic [31:0] frame_cnt;
  logic [31:0] frame_sum;
  logic [15:0] err_cnt;
  logic [3:0]  err_flags;
  logic        clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  video_axis_frame_checker #(
    .DATAW     (24),
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .bp_en         (bp_en),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tuser  (tuser),
    .s_axis_tlast  (tlast),
    .locked        (locked),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .frame_sum     (frame_sum),
    .err_cnt       (err_cnt),
    .err_flags     (err_flags),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 hunting for SOF, 1 inside a frame, 2 frame just ended
  bit          m_tready = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_mode = 0;
  int          m_col = 0;
  int          m_line = 0;
  logic [31:0] m_sum = '0;
  bit          m_ok = 1'b0;
  bit          m_locked = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_fsum = '0;
  logic [15:0] m_ecnt = '0;
  logic [3:0]  m_eflags = '0;

  task automatic model_reset();
    m_tready = 1'b0; m_lfsr = 16'hACE1; m_mode = 0; m_col = 0; m_line = 0;
    m_sum = '0; m_ok = 1'b0; m_locked = 1'b0; m_done = 1'b0; m_cnt = '0;
    m_fsum = '0; m_ecnt = '0; m_eflags = '0;
  endtask

  task automatic model_step();
    bit          beat;
    bit          start;
    logic [3:0]  set;
    logic [31:0] d;
    beat  = tvalid && m_tready;
    start = 1'b0;
    set   = '0;
    d     = 32'(tdata);
    m_done = 1'b0;
    if (beat) begin
      if (m_mode == 0) begin
        start = tuser;
      end else if (m_mode == 2) begin
        if (tuser) start = 1'b1;
        else begin set[1] = 1'b1; m_mode = 0; end
      end else begin
        if (tlast && m_col < H - 1) set[2] = 1'b1;
        if (!tlast && m_col == H - 1) set[3] = 1'b1;
        if (tuser) begin
          set[0] = 1'b1;
          start = 1'b1;
        end else begin
          m_sum = m_sum + d;
          if (tlast || m_col == H - 1) begin
            m_col = 0;
            if (m_line == V - 1) begin
              m_done = 1'b1; m_cnt = m_cnt + 1; m_fsum = m_sum;
              m_locked = m_ok && (set == 0); m_mode = 2; m_line = 0;
            end else begin
              m_line = m_line + 1;
            end
          end else begin
            m_col = m_col + 1;
          end
        end
      end
      if (start) begin
        m_mode = 1; m_sum = d; m_col = 1; m_line = 0; m_ok = (set == 0);
      end
    end
    if (set != 0) begin m_locked = 1'b0; m_ok = 1'b0; end
    if (clr_err) begin
      m_eflags = set;
      m_ecnt = (set != 0) ? 16'd1 : 16'd0;
    end else if (set != 0) begin
      m_eflags = m_eflags | set;
      if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
    end
    if (en) begin
      m_tready = !bp_en || m_lfsr[0];
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end else begin
      m_tready = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  // Compare every cycle away from the active edge
  initial forever begin
    @(negedge clk);
    check("tready", 32'(tready), 32'(m_tready));
    check("locked", 32'(locked), 32'(m_locked));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("frame_cnt", frame_cnt, m_cnt);
    check("frame_sum", frame_sum, m_fsum);
    check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
    check("err_flags", 32'(err_flags), 32'(m_eflags));
    if (frame_done) done_seen++;
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the beat was accepted
  task automatic send(input int d, input bit u, input bit l);
    int n;
    bit acc;
    n = 0;
    tdata = 24'(d); tuser = u; tlast = l; tvalid = 1'b1;
    forever begin
      acc = tready;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: tready never seen, data %0d", d);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Beats first..last of a frame carrying data 1..32
  task automatic send_part(input int first, input int last, input bit with_sof);
    for (int i = first; i <= last; i++) send(i + 1, with_sof && (i == 0), (i % H) == H - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [5:0]  seq;
    seq = 6'b001111;  // tready after seed 0xACE1: 1,1,1,1,0,0

    repeat (2) @(negedge clk);
    check("rst_tready", 32'(tready), 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_flags", 32'(err_flags), 0);
    check("rst_locked", 32'(locked), 0);

    // Backpressure from reset: seed-derived tready sequence, then lossless frames
    rst = 1'b0; en = 1'b1; bp_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("bp_seq%0d", i), 32'(tready), 32'(seq[i]));
    end
    base = done_seen;
    send_part(0, 31, 1'b1);
    send_part(0, 31, 1'b1);
    idle(); @(negedge clk);
    check("bp_cnt", frame_cnt, 2);
    check("bp_sum", frame_sum, 32'h210);
    check("bp_errcnt", 32'(err_cnt), 0);
    check("bp_done", done_seen - base, 2);

    // Clean frames without backpressure
    rst = 1'b1; @(negedge clk);
    rst = 1'b0; bp_en = 1'b0;
    base = done_seen;
    send_part(0, 31, 1'b1);
    check("clean_locked1", 32'(locked), 1);
    send_part(0, 31, 1'b1);
    idle(); @(negedge clk);
    check("clean_cnt", frame_cnt, 2);
    check("clean_sum", frame_sum, 528);
    check("clean_flags", 32'(err_flags), 0);
    check("clean_done", done_seen - base, 2);
    check("clean_locked", 32'(locked), 1);

    // Early EOL at x=5 of line 1; next beat is x=0 of line 2
    send_part(0, 7, 1'b1);
    for (int i = 0; i < 6; i++) send(9 + i, 1'b0, i == 5);
    check("eol_flags", 32'(err_flags), 32'h4);
    check("eol_errcnt", 32'(err_cnt), 1);
    check("eol_locked", 32'(locked), 0);
    for (int i = 0; i < 16; i++) send(15 + i, 1'b0, (i % H) == H - 1);
    check("eol_cnt", frame_cnt, 3);
    check("eol_sum", frame_sum, 465);

    // Frame without SOF, then a clean frame relocks
    send(100, 1'b0, 1'b0);
    check("miss_flags", 32'(err_flags), 32'h6);
    check("miss_errcnt", 32'(err_cnt), 2);
    send_part(1, 31, 1'b0);
    check("miss_discard", 32'(err_cnt), 2);
    send_part(0, 31, 1'b1);
    check("miss_cnt", frame_cnt, 4);
    check("miss_locked", 32'(locked), 1);

    // Early SOF at pixel (3,2) resyncs; following 32 beats form a frame
    base = done_seen;
    send_part(0, 18, 1'b1);
    send_part(0, 31, 1'b1);
    idle(); @(negedge clk);
    check("sofe_flags", 32'(err_flags), 32'h7);
    check("sofe_errcnt", 32'(err_cnt), 3);
    check("sofe_cnt", frame_cnt, 5);
    check("sofe_sum", frame_sum, 528);
    check("sofe_done", done_seen - base, 1);

    // Clear, then clear coinciding with an error
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("clr_flags", 32'(err_flags), 0);
    check("clr_errcnt", 32'(err_cnt), 0);
    clr_err = 1'b1;
    send(7, 1'b0, 1'b0);
    clr_err = 1'b0; idle();
    check("clrerr_flags", 32'(err_flags), 32'h2);
    check("clrerr_errcnt", 32'(err_cnt), 1);

    // Pause mid-frame with en low; frame resumes without error
    send_part(0, 11, 1'b1);
    idle(); en = 1'b0;
    repeat (5) @(negedge clk);
    check("pause_tready", 32'(tready), 0);
    en = 1'b1;
    send_part(12, 31, 1'b0);
    check("pause_cnt", frame_cnt, 6);
    check("pause_sum", frame_sum, 528);
    check("pause_locked", 32'(locked), 1);

    // Asynchronous reset at (4,1)
    send_part(0, 11, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_cnt", frame_cnt, 0);
    check("arst_sum", frame_sum, 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_tready", 32'(tready), 0);
    check("arst_errcnt", 32'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send(50 + i, 1'b0, 1'b0);
    check("seek_errcnt", 32'(err_cnt), 0);
    check("seek_cnt", frame_cnt, 0);
    send_part(0, 31, 1'b1);
    idle(); @(negedge clk);
    check("post_cnt", frame_cnt, 1);
    check("post_sum", frame_sum, 528);
    check("post_locked", 32'(locked), 1);

    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
